// File: rtl/ex_mem_if.sv
// ALU-to-memory pipeline stage bus: upstream beat, downstream beat, flush and flags.
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_flagZ;
  logic              alu_flagN;
  logic [DATA_W-1:0] store_data_in;
  logic [REG_W-1:0]  rd_in;
  logic              reg_we_in;
  logic              mem_we_in;
  logic              mem_re_in;
  logic              set_flags_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result_out;
  logic [DATA_W-1:0] store_data_out;
  logic [REG_W-1:0]  rd_out;
  logic              reg_we_out;
  logic              mem_we_out;
  logic              mem_re_out;
  logic              flag_z;
  logic              flag_n;

  // Stage side
  modport slave (
    input  flush, in_valid, alu_result, alu_flagZ, alu_flagN, store_data_in,
           rd_in, reg_we_in, mem_we_in, mem_re_in, set_flags_in, out_ready,
    output in_ready, out_valid, result_out, store_data_out, rd_out,
           reg_we_out, mem_we_out, mem_re_out, flag_z, flag_n
  );

  // Surrounding pipeline side
  modport master (
    output flush, in_valid, alu_result, alu_flagZ, alu_flagN, store_data_in,
           rd_in, reg_we_in, mem_we_in, mem_re_in, set_flags_in, out_ready,
    input  in_ready, out_valid, result_out, store_data_out, rd_out,
           reg_we_out, mem_we_out, mem_re_out, flag_z, flag_n
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry skid buffer between ALU and memory stage,
// plus the architectural Z/N flag register.
//
// state | meaning
// ------+----------------------------------------------
// EMPTY | no beat held, {main_v,skid_v} = 00
// ONE   | main holds a beat driving outputs, = 10
// FULL  | main and skid both hold beats, in_ready=0, = 11
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic   clk,
  input  logic   rst,
  ex_mem_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              reg_we;
    logic              mem_we;
    logic              mem_re;
  } beat_t;

  // Encoding doubles as the valid bits: state[1]=main_v, state[0]=skid_v.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state, state_nxt;
  beat_t  main_q, skid_q, in_beat;
  logic   main_v, skid_v;
  logic   accept, deliver;
  logic   ld_main_in, ld_main_skid, ld_skid;
  logic   flag_z_q, flag_n_q;

  assign main_v  = state[1];
  assign skid_v  = state[0];
  assign accept  = bus.in_valid && !skid_v;
  assign deliver = main_v && bus.out_ready;

  assign in_beat = {bus.alu_result, bus.store_data_in, bus.rd_in,
                    bus.reg_we_in, bus.mem_we_in, bus.mem_re_in};

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next occupancy and payload steering
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt  = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          ld_skid   = 1'b1;
        end else if (deliver) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          state_nxt    = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Payload loads are harmless on flush; only occupancy matters.
    if (bus.flush) state_nxt = EMPTY;
  end

  // Payload registers for main and skid entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_beat;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_beat;
    end
  end

  // Flags commit at acceptance since ALU flags are only valid that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (accept && bus.set_flags_in && !bus.flush) begin
      flag_z_q <= bus.alu_flagZ;
      flag_n_q <= bus.alu_flagN;
    end
  end

  assign bus.in_ready       = !skid_v;
  assign bus.out_valid      = main_v;
  assign bus.result_out     = main_q.result;
  assign bus.store_data_out = main_q.store_data;
  assign bus.rd_out         = main_q.rd;
  assign bus.reg_we_out     = main_q.reg_we;
  assign bus.mem_we_out     = main_q.mem_we;
  assign bus.mem_re_out     = main_q.mem_re;
  assign bus.flag_z         = flag_z_q;
  assign bus.flag_n         = flag_n_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage.
module tb_ex_mem_stage;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  ex_mem_if #(.DATA_W(32), .REG_W(4)) bus ();

  ex_mem_stage #(.DATA_W(32), .REG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] res, input logic sf, input logic z, input logic n);
    bus.in_valid     = 1'b1;
    bus.alu_result   = res;
    bus.set_flags_in = sf;
    bus.alu_flagZ    = z;
    bus.alu_flagN    = n;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_result = '0;
    bus.alu_flagZ = 1'b0;
    bus.alu_flagN = 1'b0;
    bus.store_data_in = '0;
    bus.rd_in = '0;
    bus.reg_we_in = 1'b0;
    bus.mem_we_in = 1'b0;
    bus.mem_re_in = 1'b0;
    bus.set_flags_in = 1'b0;
    bus.out_ready = 1'b0;

    // reset pulse mid-cycle
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_flag_z", 32'(bus.flag_z), 0);
    chk("rst_flag_n", 32'(bus.flag_n), 0);
    chk("rst_result", bus.result_out, 0);

    // single beat
    beat(32'h10, 1'b0, 1'b0, 1'b0);
    bus.rd_in = 4'd3;
    bus.reg_we_in = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_result", bus.result_out, 32'h10);
    chk("single_rd", 32'(bus.rd_out), 3);
    chk("single_reg_we", 32'(bus.reg_we_out), 1);
    chk("single_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    bus.reg_we_in = 1'b0;
    step();
    chk("single_drained", 32'(bus.out_valid), 0);

    // backpressure fill
    bus.out_ready = 1'b0;
    beat(32'hA, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_a_result", bus.result_out, 32'hA);
    chk("bp_a_in_ready", 32'(bus.in_ready), 1);
    beat(32'hB, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_full_in_ready", 32'(bus.in_ready), 0);
    chk("bp_full_result", bus.result_out, 32'hA);
    beat(32'hC, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_hold_in_ready", 32'(bus.in_ready), 0);
    chk("bp_hold_result", bus.result_out, 32'hA);
    chk("bp_hold_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    step();
    chk("bp_drain_b", bus.result_out, 32'hB);
    chk("bp_drain_ready", 32'(bus.in_ready), 1);
    step();
    chk("bp_drain_c", bus.result_out, 32'hC);
    chk("bp_drain_c_valid", 32'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    step();
    chk("bp_empty", 32'(bus.out_valid), 0);

    // flag write then skip
    beat(32'h1, 1'b1, 1'b1, 1'b0);
    step();
    chk("flag_set_z", 32'(bus.flag_z), 1);
    chk("flag_set_n", 32'(bus.flag_n), 0);
    beat(32'h2, 1'b0, 1'b0, 1'b1);
    step();
    chk("flag_skip_z", 32'(bus.flag_z), 1);
    chk("flag_skip_n", 32'(bus.flag_n), 0);
    beat(32'h3, 1'b1, 1'b0, 1'b1);
    step();
    chk("flag_set2_z", 32'(bus.flag_z), 0);
    chk("flag_set2_n", 32'(bus.flag_n), 1);
    bus.in_valid = 1'b0;
    step();

    // flush while FULL with concurrent accept attempt
    bus.out_ready = 1'b0;
    beat(32'h20, 1'b1, 1'b1, 1'b0);
    step();
    beat(32'h21, 1'b0, 1'b0, 1'b0);
    step();
    chk("fl_full_in_ready", 32'(bus.in_ready), 0);
    chk("fl_full_z", 32'(bus.flag_z), 1);
    beat(32'h22, 1'b1, 1'b0, 1'b1);
    bus.flush = 1'b1;
    step();
    chk("fl_out_valid", 32'(bus.out_valid), 0);
    chk("fl_in_ready", 32'(bus.in_ready), 1);
    chk("fl_flag_z", 32'(bus.flag_z), 1);
    // flush from EMPTY with an actual accept: beat and flag update dropped
    step();
    chk("fl2_out_valid", 32'(bus.out_valid), 0);
    chk("fl2_flag_z", 32'(bus.flag_z), 1);
    chk("fl2_flag_n", 32'(bus.flag_n), 0);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("fl_after_valid", 32'(bus.out_valid), 0);

    // full-rate pass-through with payload variety
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      beat(32'(i), 1'b0, 1'b0, 1'b0);
      bus.store_data_in = 32'(i) * 32'h0101_0101;
      bus.rd_in = 4'(i + 7);
      bus.mem_we_in = i[0];
      bus.mem_re_in = i[1];
      bus.reg_we_in = i[2];
      step();
      chk("pt_result", bus.result_out, 32'(i));
      chk("pt_valid", 32'(bus.out_valid), 1);
      chk("pt_in_ready", 32'(bus.in_ready), 1);
      chk("pt_store", bus.store_data_out, 32'(i) * 32'h0101_0101);
      chk("pt_ctl", {25'd0, bus.rd_out, bus.reg_we_out, bus.mem_we_out, bus.mem_re_out},
          {25'd0, 4'(i + 7), i[2], i[0], i[1]});
    end
    bus.in_valid = 1'b0;
    step();
    chk("pt_empty", 32'(bus.out_valid), 0);

    // async reset while FULL
    bus.out_ready = 1'b0;
    beat(32'h30, 1'b1, 1'b1, 1'b1);
    step();
    beat(32'h31, 1'b0, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    chk("ar_full", 32'(bus.in_ready), 0);
    chk("ar_flags_pre", {30'd0, bus.flag_z, bus.flag_n}, 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 0);
    chk("ar_in_ready", 32'(bus.in_ready), 1);
    chk("ar_flags", {30'd0, bus.flag_z, bus.flag_n}, 0);
    chk("ar_result", bus.result_out, 0);
    #1 rst = 1'b0;
    step();
    chk("ar_after_valid", 32'(bus.out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU. It captures the ALU result and Z/N flags plus the instruction's control and store data, and holds them for the memory stage.
- Uses a 2-entry skid buffer with valid/ready handshakes on both sides, so a stalled memory stage never loses an ALU result.
- Keeps the architectural Z/N flag register, which is written only by flag-setting instructions.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_W, 4, width of destination register index

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous discard of all buffered entries
in_valid  in  1  ALU-side beat valid
in_ready  out  1  stage can accept a beat
alu_result  in  DATA_W  ALU output C
alu_flagZ  in  1  ALU zero flag
alu_flagN  in  1  ALU N flag (A<B)
store_data_in  in  DATA_W  register value for stores
rd_in  in  REG_W  destination register
reg_we_in  in  1  writeback enable
mem_we_in  in  1  memory write
mem_re_in  in  1  memory read
set_flags_in  in  1  instruction updates flag register
out_valid  out  1  memory-side beat valid
out_ready  in  1  memory stage accepts beat
result_out  out  DATA_W  buffered ALU result (memory address or writeback value)
store_data_out  out  DATA_W  buffered store data
rd_out  out  REG_W  buffered destination
reg_we_out  out  1  buffered writeback enable
mem_we_out  out  1  buffered memory write
mem_re_out  out  1  buffered memory read
flag_z  out  1  architectural Z flag
flag_n  out  1  architectural N flag

Behaviour:
- Only one clock (clk). rst is asynchronous, active-high. All state clears on rst assertion, independent of clk.
- Reset values:
  - out_valid=0 and flag_z=flag_n=0.
  - All data and control outputs are 0.
  - in_ready=1 in the first cycle after rst deasserts.
- Storage: a main entry (drives outputs) and a skid entry. Each has a valid bit.
- States, named by {main_v, skid_v}:
  - EMPTY {0,0}
  - ONE {1,0}
  - FULL {1,1}
  - {0,1} is illegal and never reached.
- Outputs:
  - in_ready = !skid_v. It is purely registered, with no combinational path from out_ready.
  - out_valid = main_v.
- Handshake:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
  - Neither side may drop a beat or duplicate it.
- Transitions:
  - EMPTY + accept -> ONE. The beat goes to main.
  - ONE + accept, no deliver -> FULL. The beat goes to skid.
  - ONE + accept + deliver -> ONE. The new beat loads main.
  - ONE + deliver only -> EMPTY.
  - FULL + deliver -> ONE. Skid moves to main; no accept is possible because in_ready=0.
  - FULL, no deliver -> hold.
- Latency:
  - A beat accepted in cycle n appears on the outputs in cycle n+1 if the buffer was EMPTY or delivering.
  - Maximum of 2 entries in flight.
- Flag register:
  - On accept with set_flags_in=1: flag_z<=alu_flagZ and flag_n<=alu_flagN, visible in the next cycle.
  - Flags update at acceptance, not at delivery. The ALU flags are combinational and only valid during the accept cycle.
  - Accept with set_flags_in=0 leaves the flags unchanged.
- Flush (synchronous; lower priority than rst):
  - main_v=0 and skid_v=0 next cycle.
  - A beat accepted in the same cycle is discarded and its flag update is suppressed.
  - A delivery in the flush cycle still completes, because the memory side sampled it.
  - Flags are otherwise preserved; their values are unchanged by flush.
- Payload registers need not be cleared on flush; only the valid bits matter.
- Widths: all payloads pass bit-exact with no arithmetic in this block.
- rst mid-transfer: the in-flight beats are lost and flags clear. Upstream re-issue is not this block's responsibility.
- Outputs stay stable while out_valid && !out_ready.

Test Plan:
- Reset then single beat:
  - Stimulus: rst pulse mid-cycle, then in_valid=1 with alu_result=0x0000_0010, rd_in=3, reg_we_in=1, out_ready=1.
  - Response: out_valid=1 the next cycle with result_out=0x10 and rd_out=3; in_ready stays 1.
- Backpressure fill:
  - Stimulus: out_ready=0; send beats 0xA, 0xB, 0xC on consecutive cycles.
  - Response: after 0xA and 0xB the buffer is FULL and in_ready=0. 0xC is held off upstream. result_out stays 0xA.
  - Then raise out_ready: 0xA, 0xB, 0xC are delivered in order with no gaps once 0xC is accepted.
- Flag write/skip:
  - Stimulus: beat with set_flags_in=1, alu_flagZ=1, alu_flagN=0; then beat with set_flags_in=0, alu_flagZ=0, alu_flagN=1.
  - Response: flag_z=1 and flag_n=0 after the first beat, and they remain unchanged after the second.
- Flush with concurrent accept:
  - Stimulus: state FULL, flag_z=1; assert flush with in_valid=1 and set_flags_in=1, alu_flagZ=0.
  - Response: next cycle out_valid=0, in_ready=1, flag_z still 1.
- Pass-through at full rate:
  - Stimulus: in_valid=1 and out_ready=1 for 8 cycles with results 1..8.
  - Response: outputs 1..8 appear on consecutive cycles with one-cycle latency; in_ready never drops.
- Async reset while FULL:
  - Stimulus: assert rst between clock edges.
  - Response: out_valid=0, flag_z=flag_n=0, in_ready=1 immediately, without waiting for a clock edge.
